// File: rtl/wb_sdram_traffic_gen.sv
// -----------------------------------------------------------------------------
// wb_sdram_traffic_gen
//
// Wishbone initiator that exercises the sdrc_top Wishbone slave port.
// A start pulse latches base/length/seed. The block writes cfg_len words of
// an incrementing pattern (seed + i) starting at the base address, then reads
// them back and compares each word. It reports done/pass, a saturating error
// count, the byte address of the first mismatch, and an ack timeout.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   sdr_init_done            controller ready; no bus cycle starts while low
//   start                    1-cycle pulse, honoured only in IDLE or DONE
//   cfg_base/len/seed        run configuration (base bits [1:0] ignored)
//   busy, done, pass         run status (pass only meaningful while done)
//   timeout, err_cnt,
//   first_err_addr           result details
//   wb_*                     Wishbone initiator port (incrementing bursts)
//   state_dbg                current FSM state encoding, for observation
//
// Handshake: a beat completes on any cycle where wb_stb_o and wb_ack_i are
// both high; the address/data/cti of that beat are held stable until then.
// wb_ack_i seen while wb_stb_o is low is ignored.
// -----------------------------------------------------------------------------
module wb_sdram_traffic_gen #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int BL      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          sdr_init_done,
  input  logic          start,
  input  logic [AW-1:0] cfg_base,
  input  logic [15:0]   cfg_len,
  input  logic [DW-1:0] cfg_seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [2:0]    state_dbg
);

  localparam int BW = $clog2(BL + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WR_BURST  = 3'd2,
    S_WR_GAP    = 3'd3,
    S_RD_BURST  = 3'd4,
    S_RD_GAP    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] base_q, addr_q;
  logic [DW-1:0] seed_q, data_q;
  logic [15:0]   len_q, rem;
  logic [BW-1:0] beat_rem;   // beats left in the current burst
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  function automatic logic is_burst(input state_t s);
    return (s == S_WR_BURST) || (s == S_RD_BURST);
  endfunction

  function automatic logic [BW-1:0] burst_len(input logic [15:0] r);
    if (r >= 16'(BL)) return BW'(BL);
    else              return r[BW-1:0];
  endfunction

  // Last stalled cycle: stb has been high for TIMEOUT cycles once this edge passes.
  assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_next = (cfg_len == 16'd0) ? S_DONE : S_WAIT_INIT;
      S_WAIT_INIT:    if (sdr_init_done) state_next = S_WR_BURST;
      S_WR_BURST: begin
        if (wb_ack_i) begin
          if (beat_rem == BW'(1)) state_next = S_WR_GAP;
        end else if (to_hit) begin
          state_next = S_DONE;
        end
      end
      S_WR_GAP:       state_next = (rem == 16'd0) ? S_RD_BURST : S_WR_BURST;
      S_RD_BURST: begin
        if (wb_ack_i) begin
          if (beat_rem == BW'(1)) state_next = S_RD_GAP;
        end else if (to_hit) begin
          state_next = S_DONE;
        end
      end
      S_RD_GAP:       state_next = (rem == 16'd0) ? S_DONE : S_RD_BURST;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= S_IDLE;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      seed_q         <= '0;
      data_q         <= '0;
      len_q          <= '0;
      rem            <= '0;
      beat_rem       <= '0;
      to_cnt         <= '0;
    end else begin
      state    <= state_next;
      // Bus and status flags are registered from the next state so that
      // nothing on the output side depends combinationally on wb_ack_i.
      wb_cyc_o <= is_burst(state_next);
      wb_stb_o <= is_burst(state_next);
      wb_we_o  <= (state_next == S_WR_BURST);
      busy     <= !((state_next == S_IDLE) || (state_next == S_DONE));
      done     <= (state_next == S_DONE);

      if (!is_burst(state)) to_cnt <= '0;

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q         <= cfg_base & ~AW'(3);
            addr_q         <= cfg_base & ~AW'(3);
            seed_q         <= cfg_seed;
            data_q         <= cfg_seed;
            len_q          <= cfg_len;
            rem            <= cfg_len;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
          end
        end
        S_WAIT_INIT: beat_rem <= burst_len(rem);
        S_WR_BURST, S_RD_BURST: begin
          if (wb_ack_i) begin
            addr_q   <= addr_q + AW'(4);
            data_q   <= data_q + DW'(1);
            rem      <= rem - 16'd1;
            beat_rem <= beat_rem - BW'(1);
            to_cnt   <= '0;
            if ((state == S_RD_BURST) && (wb_dat_i != data_q)) begin
              if (err_cnt == 16'd0)     first_err_addr <= addr_q;
              if (err_cnt != 16'hFFFF)  err_cnt        <= err_cnt + 16'd1;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_hit) timeout <= 1'b1;
          end
        end
        S_WR_GAP: begin
          if (rem == 16'd0) begin
            // Switch to the read phase: rewind to the start of the region.
            addr_q   <= base_q;
            data_q   <= seed_q;
            rem      <= len_q;
            beat_rem <= burst_len(len_q);
          end else begin
            beat_rem <= burst_len(rem);
          end
        end
        S_RD_GAP: beat_rem <= burst_len(rem);
        default: ;
      endcase
    end
  end

  assign pass      = done && (err_cnt == 16'd0) && !timeout;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = data_q;
  assign wb_sel_o  = wb_stb_o ? 4'hF : 4'h0;
  assign wb_cti_o  = !wb_stb_o ? 3'b000 : ((beat_rem == BW'(1)) ? 3'b111 : 3'b010);
  assign state_dbg = state;

endmodule

// File: tb/tb_wb_sdram_traffic_gen.sv
module tb_wb_sdram_traffic_gen;

  localparam int AW      = 26;
  localparam int DW      = 32;
  localparam int BL      = 8;
  localparam int TIMEOUT = 1024;
  localparam int W       = 1 + AW + DW + 3;   // {we, addr, data, cti}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sdr_init_done;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [15:0]   cfg_len;
  logic [DW-1:0] cfg_seed;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;
  logic [2:0]    state_dbg;

  wb_sdram_traffic_gen #(.AW(AW), .DW(DW), .BL(BL), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done(sdr_init_done), .start(start),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [0:255];
  logic          ack;
  bit            noack   = 1'b0;
  bit            corrupt = 1'b0;
  logic [DW-1:0] rd_word;

  always @(posedge clk) begin
    if (rst) ack <= 1'b0;
    else     ack <= !noack && wb_stb_o && !(ack && wb_cti_o == 3'b111);
    if (wb_stb_o && ack && wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;
  end

  always_comb begin
    rd_word = mem[wb_addr_o[9:2]];
    if (corrupt && (wb_addr_o == 26'h114 || wb_addr_o == 26'h144))
      rd_word = rd_word ^ 32'h0000_0100;
  end

  assign wb_ack_i = ack;
  assign wb_dat_i = rd_word;

  // ---------------- bus monitor ----------------
  bit mon_clr = 1'b0;
  bit cyc_prev;
  int burst_cnt, gap_total, low_run, stb_run, last_stb_run, stb_hi, cyc_noinit;

  always @(negedge clk) begin
    if (mon_clr) begin
      burst_cnt = 0; gap_total = 0; low_run = 0; stb_run = 0;
      last_stb_run = 0; stb_hi = 0; cyc_noinit = 0; cyc_prev = 1'b0;
      obs_q.delete();
    end else begin
      if (wb_cyc_o) begin
        if (!cyc_prev) begin
          burst_cnt++;
          if (burst_cnt > 1) gap_total += low_run;
        end
        low_run = 0;
        if (!sdr_init_done) cyc_noinit++;
      end else begin
        low_run++;
      end
      if (wb_stb_o) begin
        stb_run++;
        stb_hi++;
      end else if (stb_run != 0) begin
        last_stb_run = stb_run;
        stb_run = 0;
      end
      if (wb_cyc_o && wb_stb_o && wb_ack_i)
        obs_q.push_back({wb_we_o, wb_addr_o, (wb_we_o ? wb_dat_o : {DW{1'b0}}), wb_cti_o});
      cyc_prev = wb_cyc_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; noack = 1'b0; corrupt = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_start(input logic [AW-1:0] b, input logic [15:0] l, input logic [DW-1:0] s);
    cfg_base = b; cfg_len = l; cfg_seed = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference bus trace: write phase then read phase, bursts of up to BL beats.
  function automatic void push_expected(input logic [AW-1:0] base, input int len, input logic [DW-1:0] seed);
    logic [AW-1:0] b, a;
    logic [DW-1:0] d;
    logic [2:0]    cti;
    int            j, sz;
    b = base & ~AW'(3);
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < len; i++) begin
        j   = i % BL;
        sz  = (len - (i - j) < BL) ? len - (i - j) : BL;
        cti = (j == sz - 1) ? 3'b111 : 3'b010;
        a   = b + AW'(4 * i);
        d   = (ph == 0) ? seed + DW'(i) : {DW{1'b0}};
        exp_q.push_back({(ph == 0), a, d, cti});
      end
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [116:0] outs;
    do_reset();
    outs = {busy, done, pass, timeout, err_cnt, first_err_addr, wb_cyc_o, wb_stb_o,
            wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o, state_dbg};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outputs act=%h exp=0", outs);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [W-1:0] e, o;
    do_reset(); sdr_init_done = 1'b1; clear_mon();
    push_expected(26'h100, 20, 32'hA5A5_0000);
    run_start(26'h100, 16'd20, 32'hA5A5_0000);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start act=%b exp=1", busy); end
    repeat (5) tick();
    run_start(26'h300, 16'd3, 32'h1234_5678);   // must be ignored while busy
    wait_done(500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done_wait act=timeout exp=done"); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done act=%b exp=0", busy); end
    total++;
    if ({pass, timeout, err_cnt, first_err_addr} !== {1'b1, 1'b0, 16'd0, 26'd0}) begin
      bad++; $display("FAIL basic_result act=pass%b to%b err%0d fa%h exp=pass1 to0 err0 fa0",
                      pass, timeout, err_cnt, first_err_addr);
    end
    tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_beat_count act=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL basic_beat act=%h exp=%h", o, e); end
    end
    total++;
    if ({burst_cnt, gap_total, stb_hi} !== {32'd6, 32'd5, 32'd46}) begin
      bad++; $display("FAIL basic_bursts act=b%0d g%0d s%0d exp=b6 g5 s46", burst_cnt, gap_total, stb_hi);
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    do_reset(); sdr_init_done = 1'b1; clear_mon();
    corrupt = 1'b1;
    run_start(26'h100, 16'd20, 32'hA5A5_0000);
    wait_done(500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL corrupt_done_wait act=timeout exp=done"); end
    total++;
    if (err_cnt !== 16'd2) begin bad++; $display("FAIL corrupt_err_cnt act=%0d exp=2", err_cnt); end
    total++;
    if (first_err_addr !== 26'h114) begin
      bad++; $display("FAIL corrupt_first_addr act=%h exp=114", first_err_addr);
    end
    total++;
    if (pass !== 1'b0) begin bad++; $display("FAIL corrupt_pass act=%b exp=0", pass); end
    corrupt = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset(); sdr_init_done = 1'b1; clear_mon();
    noack = 1'b1;
    run_start(26'h100, 16'd20, 32'hA5A5_0000);
    wait_done(TIMEOUT + 50, ok);
    tick();
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_done_wait act=timeout exp=done"); end
    total++;
    if ({wb_cyc_o, wb_stb_o, timeout, pass, busy} !== 5'b00100) begin
      bad++; $display("FAIL timeout_flags act=cyc%b stb%b to%b pass%b busy%b exp=cyc0 stb0 to1 pass0 busy0",
                      wb_cyc_o, wb_stb_o, timeout, pass, busy);
    end
    total++;
    if (last_stb_run != TIMEOUT) begin
      bad++; $display("FAIL timeout_stb_cycles act=%0d exp=%0d", last_stb_run, TIMEOUT);
    end
    noack = 1'b0;
  endtask

  task automatic test_zero_len();
    bit seen;
    do_reset(); sdr_init_done = 1'b1; clear_mon();
    run_start(26'h200, 16'd0, 32'hDEAD_BEEF);
    seen = done;
    if (!seen) begin tick(); seen = done; end
    total++;
    if (!seen) begin bad++; $display("FAIL zero_len_done act=0 exp=1"); end
    total++;
    if (pass !== 1'b1) begin bad++; $display("FAIL zero_len_pass act=%b exp=1", pass); end
    repeat (5) tick();
    total++;
    if (burst_cnt != 0) begin bad++; $display("FAIL zero_len_no_cyc act=%0d exp=0", burst_cnt); end
  endtask

  task automatic test_wait_init();
    bit ok;
    logic [W-1:0] e, o;
    do_reset(); sdr_init_done = 1'b0; clear_mon();
    push_expected(26'h100, 20, 32'h0BAD_F00D);
    run_start(26'h100, 16'd20, 32'h0BAD_F00D);
    repeat (50) tick();
    total++;
    if ({busy, burst_cnt} !== {1'b1, 32'd0}) begin
      bad++; $display("FAIL init_hold act=busy%b bursts%0d exp=busy1 bursts0", busy, burst_cnt);
    end
    sdr_init_done = 1'b1;
    wait_done(500, ok);
    tick();
    total++;
    if (!ok || pass !== 1'b1) begin bad++; $display("FAIL init_run act=ok%b pass%b exp=ok1 pass1", ok, pass); end
    total++;
    if (cyc_noinit != 0) begin bad++; $display("FAIL init_cyc_early act=%0d exp=0", cyc_noinit); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL init_beat_count act=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL init_beat act=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [W-1:0] e, o;
    do_reset(); sdr_init_done = 1'b1; clear_mon();
    run_start(26'h100, 16'd20, 32'h5555_0000);
    for (int c = 0; c < 50 && obs_q.size() < 3; c++) tick();
    total++;
    if (obs_q.size() < 3 || !wb_cyc_o) begin
      bad++; $display("FAIL midrst_setup act=beats%0d cyc%b exp=beats>=3 cyc1", obs_q.size(), wb_cyc_o);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({wb_cyc_o, wb_stb_o, busy, done} !== 4'b0000) begin
      bad++; $display("FAIL midrst_outputs act=%b exp=0000", {wb_cyc_o, wb_stb_o, busy, done});
    end
    rst = 1'b0;
    clear_mon();
    push_expected(26'h100, 20, 32'h7777_0000);
    run_start(26'h100, 16'd20, 32'h7777_0000);
    wait_done(500, ok);
    tick();
    total++;
    if (!ok || pass !== 1'b1) begin bad++; $display("FAIL midrst_rerun act=ok%b pass%b exp=ok1 pass1", ok, pass); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL midrst_beat_count act=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL midrst_beat act=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    logic [AW-1:0] b;
    logic [DW-1:0] s;
    logic [W-1:0]  e, o;
    do_reset(); sdr_init_done = 1'b1;
    for (int it = 0; it < 3; it++) begin
      clear_mon();
      len = $urandom_range(1, 30);
      b   = AW'($urandom_range(0, 200) * 4 + $urandom_range(0, 3));
      s   = $urandom;
      push_expected(b, len, s);
      run_start(b, 16'(len), s);
      wait_done(600, ok);
      tick();
      total++;
      if (!ok || pass !== 1'b1) begin bad++; $display("FAIL rand_run it%0d act=ok%b pass%b exp=ok1 pass1", it, ok, pass); end
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand_beat_count it%0d act=%0d exp=%0d", it, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++;
        if (o !== e) begin bad++; $display("FAIL rand_beat it%0d act=%h exp=%h", it, o, e); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; sdr_init_done = 1'b1; start = 1'b0;
    cfg_base = '0; cfg_len = '0; cfg_seed = '0;
    test_reset();
    test_basic();
    test_corrupt();
    test_timeout();
    test_zero_len();
    test_wait_init();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
